ahb_lite_bus_arbiter: RTL and testbench



---
 rtl/ahb_lite_pkg.sv | 38 +++
 rtl/ahb_input_stage.sv | 58 +++++
 rtl/ahb_lite_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_ahb_lite_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_pkg
//  Description : Shared AHB-Lite encodings and the address-phase record used
//                by the two-port bus arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package ahb_lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Index of an upstream port: 0 = instruction side, 1 = data side.
    typedef logic port_idx_t;

    // Everything a master presents in its address phase.
    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  size;
        logic        write;
    } ahb_ap_t;

    localparam ahb_ap_t AP_IDLE = '{addr: 32'h0, trans: HTRANS_IDLE,
                                    size: HSIZE_WORD, write: 1'b0};

    // NONSEQ and SEQ both carry bit 1 set; they are the only real beats.
    function automatic logic trans_active(input logic [1:0] trans);
        return trans[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_input_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_input_stage
//  Description : Per-port front end. Detects a live request, parks a transfer
//                that could not be forwarded and generates the port's HREADY.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_input_stage
    import ahb_lite_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  ahb_ap_t i_live,        // address phase as driven by the master
    input  logic    i_fwd,         // this port is granted and the bus is ready
    input  logic    i_beat_clr,    // a beat of this port was taken on the bus
    input  logic    i_bus_hready,
    input  logic    i_dphase_mine, // the outstanding data phase belongs here
    output logic    o_req,
    output ahb_ap_t o_src,
    output logic    o_pend_valid,
    output logic    o_hready
);

    ahb_ap_t r_pend;
    logic    r_pend_valid;
    logic    w_live_req;

    // Port ready: stalled while a parked transfer waits, else follows its own data phase.
    always_comb begin
        o_hready = 1'b1;
        if (r_pend_valid) begin
            o_hready = 1'b0;
        end else if (i_dphase_mine) begin
            o_hready = i_bus_hready;
        end
    end

    // A master only issues a transfer in a cycle where it sees its HREADY high.
    assign w_live_req   = trans_active(i_live.trans) && o_hready;
    assign o_req        = r_pend_valid || w_live_req;
    assign o_src        = r_pend_valid ? r_pend : i_live;
    assign o_pend_valid = r_pend_valid;

    // Park a live transfer the bus did not accept; release it once it is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_valid <= 1'b0;
            r_pend       <= AP_IDLE;
        end else if (w_live_req && !i_fwd) begin
            r_pend_valid <= 1'b1;
            r_pend       <= i_live;
        end else if (i_beat_clr) begin
            r_pend_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ahb_lite_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_bus_arbiter
//  Description : Two-master AHB-Lite arbiter in front of one memory port.
//                Owner traffic passes through combinationally; a beat budget
//                hands the bus over when the other port is waiting.
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_lite_bus_arbiter
    import ahb_lite_pkg::*;
#(
    parameter int MAX_BEATS   = 8,
    parameter bit RESET_OWNER = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] s0_haddr,
    input  logic [1:0]  s0_htrans,
    output logic [31:0] s0_hrdata,
    output logic        s0_hready,
    input  logic [31:0] s1_haddr,
    input  logic [1:0]  s1_htrans,
    input  logic [2:0]  s1_hsize,
    input  logic        s1_hwrite,
    input  logic [31:0] s1_hwdata,
    output logic [31:0] s1_hrdata,
    output logic        s1_hready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    output logic        HMASTER
);

    localparam int                 c_cnt_w     = $clog2(MAX_BEATS + 1);
    localparam logic [c_cnt_w-1:0] c_max_beats = c_cnt_w'(MAX_BEATS);

    ahb_ap_t [1:0]      w_live;
    ahb_ap_t [1:0]      w_src;
    logic    [1:0]      w_req;
    logic    [1:0]      w_pend_valid;
    logic    [1:0]      w_shready;
    ahb_ap_t            w_ap;
    port_idx_t          w_grant;
    port_idx_t          w_other;
    logic               w_seq_ok;
    logic               w_beat;

    port_idx_t          r_owner;
    logic [c_cnt_w-1:0] r_beat_cnt;
    logic               r_lock;
    ahb_ap_t            r_lock_ap;
    port_idx_t          r_lock_master;
    logic               r_dphase_valid;
    port_idx_t          r_dphase_owner;
    logic               r_prev_valid;
    port_idx_t          r_prev_master;

    // The instruction port is always a read of a full word.
    assign w_live[0] = '{addr: s0_haddr, trans: s0_htrans, size: HSIZE_WORD, write: 1'b0};
    assign w_live[1] = '{addr: s1_haddr, trans: s1_htrans, size: s1_hsize,   write: s1_hwrite};

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        ahb_input_stage u_stage (
            .clk           (HCLK),
            .rst           (HRESET),
            .i_live        (w_live[gi]),
            .i_fwd         ((w_grant == 1'(gi)) && HREADY),
            .i_beat_clr    (w_beat && (w_grant == 1'(gi))),
            .i_bus_hready  (HREADY),
            .i_dphase_mine (r_dphase_valid && (r_dphase_owner == 1'(gi))),
            .o_req         (w_req[gi]),
            .o_src         (w_src[gi]),
            .o_pend_valid  (w_pend_valid[gi]),
            .o_hready      (w_shready[gi])
        );
    end

    // Grant: a stalled address phase pins the master; else owner keeps the bus within its budget.
    always_comb begin
        w_other = ~r_owner;
        if (HRESET) begin
            w_grant = RESET_OWNER;
        end else if (r_lock) begin
            w_grant = r_lock_master;
        end else if (w_req[r_owner] && !(w_req[w_other] && (r_beat_cnt >= c_max_beats))) begin
            w_grant = r_owner;
        end else if (w_req[w_other]) begin
            w_grant = w_other;
        end else begin
            w_grant = r_owner;
        end
    end

    // SEQ only stays SEQ when it directly follows this port's previous beat.
    assign w_seq_ok = r_prev_valid && (r_prev_master == w_grant) && !w_pend_valid[w_grant];

    // Bus address phase: held while stalled, else the granted source, else BUSY or IDLE.
    always_comb begin
        w_ap = AP_IDLE;
        if (HRESET) begin
            w_ap = AP_IDLE;
        end else if (r_lock) begin
            w_ap = r_lock_ap;
        end else if (w_req[w_grant]) begin
            w_ap = w_src[w_grant];
            if ((w_ap.trans == HTRANS_SEQ) && !w_seq_ok) begin
                w_ap.trans = HTRANS_NONSEQ;
            end
        end else if (w_live[w_grant].trans == HTRANS_BUSY) begin
            w_ap = w_live[w_grant];
        end
    end

    assign w_beat    = HREADY && trans_active(w_ap.trans);

    assign HADDR     = w_ap.addr;
    assign HTRANS    = w_ap.trans;
    assign HSIZE     = w_ap.size;
    assign HWRITE    = w_ap.write;
    assign HBURST    = HBURST_INCR;
    assign HWDATA    = s1_hwdata;
    assign HMASTER   = w_grant;
    assign s0_hrdata = HRDATA;
    assign s1_hrdata = HRDATA;
    assign s0_hready = w_shready[0];
    assign s1_hready = w_shready[1];

    // Ownership and beat budget; a handover that carries a beat counts it for the new owner.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_owner    <= RESET_OWNER;
            r_beat_cnt <= '0;
        end else begin
            r_owner <= w_grant;
            if (w_grant != r_owner) begin
                r_beat_cnt <= w_beat ? c_cnt_w'(1) : '0;
            end else if (w_beat && (r_beat_cnt < c_max_beats)) begin
                r_beat_cnt <= r_beat_cnt + c_cnt_w'(1);
            end
        end
    end

    // Freeze the address phase of an active transfer until the bus accepts it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_lock        <= 1'b0;
            r_lock_ap     <= AP_IDLE;
            r_lock_master <= RESET_OWNER;
        end else if (HREADY) begin
            r_lock <= 1'b0;
        end else if (!r_lock && trans_active(w_ap.trans)) begin
            r_lock        <= 1'b1;
            r_lock_ap     <= w_ap;
            r_lock_master <= w_grant;
        end
    end

    // Track whose data phase is outstanding and who issued the most recent beat.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dphase_valid <= 1'b0;
            r_dphase_owner <= RESET_OWNER;
            r_prev_valid   <= 1'b0;
            r_prev_master  <= RESET_OWNER;
        end else begin
            if (HREADY) begin
                r_dphase_valid <= w_beat;
                if (w_beat) begin
                    r_dphase_owner <= w_grant;
                end
            end
            if (w_beat) begin
                r_prev_valid  <= 1'b1;
                r_prev_master <= w_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_lite_bus_arbiter
//  Description : Directed self-checking bench for ahb_lite_bus_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_lite_bus_arbiter;
    import ahb_lite_pkg::*;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] s0_haddr;
    logic [1:0]  s0_htrans;
    logic [31:0] s0_hrdata;
    logic        s0_hready;
    logic [31:0] s1_haddr;
    logic [1:0]  s1_htrans;
    logic [2:0]  s1_hsize;
    logic        s1_hwrite;
    logic [31:0] s1_hwdata;
    logic [31:0] s1_hrdata;
    logic        s1_hready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HMASTER;

    int errors = 0;
    int checks = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_bus_arbiter #(.MAX_BEATS(8), .RESET_OWNER(1'b0)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .s0_haddr(s0_haddr), .s0_htrans(s0_htrans), .s0_hrdata(s0_hrdata), .s0_hready(s0_hready),
        .s1_haddr(s1_haddr), .s1_htrans(s1_htrans), .s1_hsize(s1_hsize), .s1_hwrite(s1_hwrite),
        .s1_hwdata(s1_hwdata), .s1_hrdata(s1_hrdata), .s1_hready(s1_hready),
        .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HMASTER(HMASTER)
    );

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        s0_haddr  = 32'h0;  s0_htrans = HTRANS_IDLE;
        s1_haddr  = 32'h0;  s1_htrans = HTRANS_IDLE;
        s1_hsize  = HSIZE_WORD; s1_hwrite = 1'b0; s1_hwdata = 32'h0;
        HRDATA    = 32'h0;  HREADY    = 1'b1;
    endtask

    task automatic do_reset();
        drive_idle();
        HRESET = 1'b1;
        tick();
        tick();
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR} !== {1'b0, HTRANS_IDLE, 32'h0}) begin
            errors++; $display("FAIL reset_ap: got %h expected %h", {HMASTER, HTRANS, HADDR}, {1'b0, HTRANS_IDLE, 32'h0});
        end
        checks++;
        if ({HWRITE, HSIZE, HBURST} !== {1'b0, 3'b010, 3'b001}) begin
            errors++; $display("FAIL reset_ctrl: got %h expected %h", {HWRITE, HSIZE, HBURST}, {1'b0, 3'b010, 3'b001});
        end
        checks++;
        if ({s0_hready, s1_hready} !== 2'b11) begin
            errors++; $display("FAIL reset_hready: got %b expected 11", {s0_hready, s1_hready});
        end
    endtask

    task automatic test_passthrough();
        logic [31:0] a;
        logic [1:0]  t;
        for (int k = 0; k < 3; k++) begin
            a = 32'h100 + 32'(4 * k);
            t = (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            s0_haddr = a; s0_htrans = t;
            #1;
            checks++;
            if ({HMASTER, HTRANS, HADDR} !== {1'b0, t, a}) begin
                errors++; $display("FAIL pass_ap[%0d]: got %h expected %h", k, {HMASTER, HTRANS, HADDR}, {1'b0, t, a});
            end
            checks++;
            if ({s0_hready, HWRITE, HSIZE} !== {1'b1, 1'b0, 3'b010}) begin
                errors++; $display("FAIL pass_ctrl[%0d]: got %h expected %h", k, {s0_hready, HWRITE, HSIZE}, {1'b1, 1'b0, 3'b010});
            end
            tick();
        end
        s0_htrans = HTRANS_IDLE; HRDATA = 32'h1234_5678;
        #1;
        checks++;
        if ({s0_hready, HTRANS} !== {1'b1, HTRANS_IDLE}) begin
            errors++; $display("FAIL pass_end: got %h expected %h", {s0_hready, HTRANS}, {1'b1, HTRANS_IDLE});
        end
        checks++;
        if ({s0_hrdata, s1_hrdata} !== {32'h1234_5678, 32'h1234_5678}) begin
            errors++; $display("FAIL rdata_bcast: got %h expected %h", {s0_hrdata, s1_hrdata}, {32'h1234_5678, 32'h1234_5678});
        end
        tick();
    endtask

    task automatic test_budget();
        logic [31:0] a;
        do_reset();
        s0_haddr = 32'h100;  s0_htrans = HTRANS_NONSEQ;
        s1_haddr = 32'h2000; s1_htrans = HTRANS_NONSEQ;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR, s1_hready} !== {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1}) begin
            errors++; $display("FAIL budget_first: got %h expected %h", {HMASTER, HTRANS, HADDR, s1_hready}, {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1});
        end
        tick();
        s1_htrans = HTRANS_IDLE; s1_haddr = 32'h0;
        for (int k = 1; k < 8; k++) begin
            a = 32'h100 + 32'(4 * k);
            s0_haddr = a; s0_htrans = HTRANS_SEQ;
            #1;
            checks++;
            if ({HMASTER, HTRANS, HADDR, s1_hready} !== {1'b0, HTRANS_SEQ, a, 1'b0}) begin
                errors++; $display("FAIL budget_stream[%0d]: got %h expected %h", k, {HMASTER, HTRANS, HADDR, s1_hready}, {1'b0, HTRANS_SEQ, a, 1'b0});
            end
            tick();
        end
        s0_haddr = 32'h120; s0_htrans = HTRANS_SEQ;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR} !== {1'b1, HTRANS_NONSEQ, 32'h2000}) begin
            errors++; $display("FAIL budget_handover: got %h expected %h", {HMASTER, HTRANS, HADDR}, {1'b1, HTRANS_NONSEQ, 32'h2000});
        end
        tick();
        s0_htrans = HTRANS_IDLE; s0_haddr = 32'h0;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR, s0_hready} !== {1'b0, HTRANS_NONSEQ, 32'h120, 1'b0}) begin
            errors++; $display("FAIL budget_resume: got %h expected %h", {HMASTER, HTRANS, HADDR, s0_hready}, {1'b0, HTRANS_NONSEQ, 32'h120, 1'b0});
        end
        tick();
        #1;
        checks++;
        if ({HTRANS, s0_hready} !== {HTRANS_IDLE, 1'b1}) begin
            errors++; $display("FAIL budget_drain: got %h expected %h", {HTRANS, s0_hready}, {HTRANS_IDLE, 1'b1});
        end
    endtask

    task automatic test_busy_write();
        do_reset();
        s0_haddr = 32'h108; s0_htrans = HTRANS_NONSEQ;
        tick();
        s0_haddr = 32'h10C; s0_htrans = HTRANS_BUSY;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR} !== {1'b0, HTRANS_BUSY, 32'h10C}) begin
            errors++; $display("FAIL busy_fwd: got %h expected %h", {HMASTER, HTRANS, HADDR}, {1'b0, HTRANS_BUSY, 32'h10C});
        end
        tick();
        s1_haddr = 32'h2000; s1_htrans = HTRANS_NONSEQ; s1_hwrite = 1'b1;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR, HWRITE} !== {1'b1, HTRANS_NONSEQ, 32'h2000, 1'b1}) begin
            errors++; $display("FAIL busy_preempt: got %h expected %h", {HMASTER, HTRANS, HADDR, HWRITE}, {1'b1, HTRANS_NONSEQ, 32'h2000, 1'b1});
        end
        tick();
        s1_htrans = HTRANS_IDLE; s1_hwrite = 1'b0; s1_hwdata = 32'hDEAD_BEEF;
        s0_htrans = HTRANS_SEQ;
        #1;
        checks++;
        if (HWDATA !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL busy_wdata: got %h expected %h", HWDATA, 32'hDEAD_BEEF);
        end
        checks++;
        if ({HMASTER, HTRANS, HADDR, HWRITE, s1_hready} !== {1'b0, HTRANS_NONSEQ, 32'h10C, 1'b0, 1'b1}) begin
            errors++; $display("FAIL busy_resume: got %h expected %h", {HMASTER, HTRANS, HADDR, HWRITE, s1_hready}, {1'b0, HTRANS_NONSEQ, 32'h10C, 1'b0, 1'b1});
        end
        tick();
        drive_idle();
    endtask

    task automatic test_hready_stall();
        do_reset();
        s1_haddr = 32'h3000; s1_htrans = HTRANS_NONSEQ;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR} !== {1'b1, HTRANS_NONSEQ, 32'h3000}) begin
            errors++; $display("FAIL stall_d1: got %h expected %h", {HMASTER, HTRANS, HADDR}, {1'b1, HTRANS_NONSEQ, 32'h3000});
        end
        tick();
        s1_htrans = HTRANS_IDLE; s1_haddr = 32'h0;
        s0_haddr = 32'h100; s0_htrans = HTRANS_NONSEQ; HREADY = 1'b0;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR, s0_hready, s1_hready} !== {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1, 1'b0}) begin
            errors++; $display("FAIL stall_c1: got %h expected %h", {HMASTER, HTRANS, HADDR, s0_hready, s1_hready}, {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1, 1'b0});
        end
        tick();
        s0_htrans = HTRANS_IDLE; s0_haddr = 32'h0;
        for (int k = 2; k < 4; k++) begin
            #1;
            checks++;
            if ({HMASTER, HTRANS, HADDR, s0_hready, s1_hready} !== {1'b0, HTRANS_NONSEQ, 32'h100, 1'b0, 1'b0}) begin
                errors++; $display("FAIL stall_c%0d: got %h expected %h", k, {HMASTER, HTRANS, HADDR, s0_hready, s1_hready}, {1'b0, HTRANS_NONSEQ, 32'h100, 1'b0, 1'b0});
            end
            tick();
        end
        HREADY = 1'b1;
        #1;
        checks++;
        if ({HMASTER, HTRANS, HADDR, s1_hready} !== {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1}) begin
            errors++; $display("FAIL stall_release: got %h expected %h", {HMASTER, HTRANS, HADDR, s1_hready}, {1'b0, HTRANS_NONSEQ, 32'h100, 1'b1});
        end
        tick();
        #1;
        checks++;
        if ({HTRANS, s0_hready} !== {HTRANS_IDLE, 1'b1}) begin
            errors++; $display("FAIL stall_done: got %h expected %h", {HTRANS, s0_hready}, {HTRANS_IDLE, 1'b1});
        end
    endtask

    task automatic test_reset_midop();
        do_reset();
        s0_haddr = 32'h100;  s0_htrans = HTRANS_NONSEQ;
        s1_haddr = 32'h2000; s1_htrans = HTRANS_NONSEQ;
        tick();
        s1_htrans = HTRANS_IDLE; s1_haddr = 32'h0;
        s0_haddr = 32'h104; s0_htrans = HTRANS_SEQ;
        #1;
        checks++;
        if (s1_hready !== 1'b0) begin
            errors++; $display("FAIL midrst_pended: got %b expected 0", s1_hready);
        end
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        drive_idle();
        #1;
        checks++;
        if ({HMASTER, HTRANS, s0_hready, s1_hready} !== {1'b0, HTRANS_IDLE, 1'b1, 1'b1}) begin
            errors++; $display("FAIL midrst_state: got %h expected %h", {HMASTER, HTRANS, s0_hready, s1_hready}, {1'b0, HTRANS_IDLE, 1'b1, 1'b1});
        end
        tick();
        #1;
        checks++;
        if ({HTRANS, HADDR} !== {HTRANS_IDLE, 32'h0}) begin
            errors++; $display("FAIL midrst_dropped: got %h expected %h", {HTRANS, HADDR}, {HTRANS_IDLE, 32'h0});
        end
    endtask

    initial begin
        HRESET = 1'b1;
        drive_idle();
        test_reset();
        test_passthrough();
        test_budget();
        test_busy_write();
        test_hready_stall();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
